fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined CPU.
- Owns the PC and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers up to two returned instructions and presents them, with their PC, to the IF/ID pipeline register.
- Honours the hazard unit's `stall` and the EX-stage branch/jump redirect, which flushes everything in flight.

---
 rtl/fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_fetch_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage; owns the PC, issues in-order imem requests, buffers two returns.
// Define FETCH_STATS_EN to add the fetch_count / flush_count statistics outputs.
//
// state | meaning
// RUN   | drop_cnt == 0, responses are written into the output buffer
// FLUSH | drop_cnt >  0, responses belong to a squashed path and are discarded
module fetch_unit #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32,
    parameter logic [ADDR_LEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [ADDR_LEN-1:0] redirect_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [ADDR_LEN-1:0] imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [DATA_LEN-1:0] imem_resp_data,
    output logic                inst_valid_out,
    output logic [DATA_LEN-1:0] inst_out,
    output logic [ADDR_LEN-1:0] pc_out
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]         fetch_count,
    output logic [15:0]         flush_count
`endif
);

    typedef enum logic {RUN, FLUSH} phase_t;

    phase_t              phase;
    logic [1:0]          drop_cnt;
    logic [1:0]          drop_nxt;
    logic [ADDR_LEN-1:0] pc_q;
    logic [ADDR_LEN-1:0] tag_q [2];
    logic [1:0]          tag_cnt;
    logic [ADDR_LEN-1:0] buf_pc [2];
    logic [DATA_LEN-1:0] buf_inst [2];
    logic [1:0]          buf_cnt;
    logic [ADDR_LEN-1:0] redirect_aligned;
    logic                req_fire;
    logic                resp_keep;
    logic                head_pop;

    assign redirect_aligned = redirect_pc & ~ADDR_LEN'(3);

    // Credit rule: outstanding plus buffered never exceeds the buffer depth.
    assign imem_req_valid = rst & ~redirect_valid & (({1'b0, tag_cnt} + {1'b0, buf_cnt}) < 3'd2);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign resp_keep      = imem_resp_valid & ~redirect_valid & (phase == RUN);
    assign head_pop       = inst_valid_out & ~stall & ~redirect_valid;

    assign inst_valid_out = (buf_cnt != 2'd0);
    assign inst_out       = inst_valid_out ? buf_inst[0] : '0;
    assign pc_out         = inst_valid_out ? buf_pc[0]   : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= 2'd0;
        end else begin
            drop_cnt <= drop_nxt;
        end
    end

    always_comb begin
        phase    = (drop_cnt == 2'd0) ? RUN : FLUSH;
        drop_nxt = drop_cnt;
        if (redirect_valid) begin
            // every request still in flight now belongs to the squashed path
            drop_nxt = tag_cnt - {1'b0, imem_resp_valid};
        end else if (imem_resp_valid && (phase == FLUSH)) begin
            drop_nxt = drop_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_aligned;
        end else if (req_fire) begin
            pc_q <= pc_q + ADDR_LEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_cnt  <= 2'd0;
            tag_q[0] <= '0;
            tag_q[1] <= '0;
        end else begin
            case ({req_fire, imem_resp_valid})
                2'b10: begin
                    tag_q[tag_cnt[0]] <= pc_q;
                    tag_cnt           <= tag_cnt + 2'd1;
                end
                2'b01: begin
                    tag_q[0] <= tag_q[1];
                    tag_cnt  <= tag_cnt - 2'd1;
                end
                2'b11: begin
                    if (tag_cnt == 2'd1) begin
                        tag_q[0] <= pc_q;
                    end else begin
                        tag_q[0] <= tag_q[1];
                        tag_q[1] <= pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_cnt     <= 2'd0;
            buf_pc[0]   <= '0;
            buf_pc[1]   <= '0;
            buf_inst[0] <= '0;
            buf_inst[1] <= '0;
        end else if (redirect_valid) begin
            buf_cnt <= 2'd0;
        end else begin
            case ({resp_keep, head_pop})
                2'b10: begin
                    buf_pc[buf_cnt[0]]   <= tag_q[0];
                    buf_inst[buf_cnt[0]] <= imem_resp_data;
                    buf_cnt              <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf_pc[0]   <= buf_pc[1];
                    buf_inst[0] <= buf_inst[1];
                    buf_cnt     <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf_pc[0]   <= tag_q[0];
                        buf_inst[0] <= imem_resp_data;
                    end else begin
                        buf_pc[0]   <= buf_pc[1];
                        buf_inst[0] <= buf_inst[1];
                        buf_pc[1]   <= tag_q[0];
                        buf_inst[1] <= imem_resp_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= 32'd0;
            flush_count <= 16'd0;
        end else begin
            if (resp_keep && (fetch_count != 32'hFFFF_FFFF)) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redirect_valid) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue-based memory and reference model checked every cycle.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif

    fetch_unit #(.ADDR_LEN(32), .DATA_LEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid_out(inst_valid_out), .inst_out(inst_out), .pc_out(pc_out)
`ifdef FETCH_STATS_EN
        , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; bit stale;} tag_t;
    typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
    typedef struct {logic [31:0] addr; int due;} mreq_t;

    tag_t        m_out[$];
    ent_t        m_buf[$];
    mreq_t       mem_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_fetch;
    logic [15:0] m_flush;
    logic        exp_rv;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          stall_pct, ready_pct, redir_pct, lat_lo, lat_hi;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic model_reset();
        m_out.delete();
        m_buf.delete();
        mem_q.delete();
        m_pc    = RST_PC;
        m_fetch = '0;
        m_flush = '0;
    endtask

    // Applies one clock edge of architectural behaviour to the memory and reference model.
    task automatic model_step();
        bit   fire;
        bit   do_pop;
        int   lat;
        tag_t t;
        fire   = exp_rv && imem_req_ready;
        do_pop = (m_buf.size() > 0) && !stall;
        if (imem_resp_valid) void'(mem_q.pop_front());
        if (fire) begin
            lat = $urandom_range(lat_hi, lat_lo);
            mem_q.push_back('{m_pc, cyc + lat});
        end
        if (redirect_valid) begin
            foreach (m_out[i]) m_out[i].stale = 1'b1;
            if (imem_resp_valid) void'(m_out.pop_front());
            m_buf.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            m_flush = m_flush + 16'd1;
        end else begin
            if (imem_resp_valid) begin
                t = m_out.pop_front();
                if (!t.stale) begin
                    m_buf.push_back('{t.addr, imem_resp_data});
                    if (m_fetch != 32'hFFFF_FFFF) m_fetch = m_fetch + 32'd1;
                end
            end
            if (do_pop) void'(m_buf.pop_front());
            if (fire) begin
                m_out.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        logic        exp_iv;
        logic [31:0] exp_inst, exp_pc;
        int          mode;
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = !((c < 3) || (c >= 2000 && c < 2003));
            if (!rst) model_reset();
            mode = (c / 300) % 4;
            case (mode)
                0:       begin stall_pct = 0;  ready_pct = 100; redir_pct = 0;  lat_lo = 1; lat_hi = 1; end
                1:       begin stall_pct = 40; ready_pct = 70;  redir_pct = 5;  lat_lo = 1; lat_hi = 3; end
                2:       begin stall_pct = 10; ready_pct = 40;  redir_pct = 8;  lat_lo = 2; lat_hi = 3; end
                default: begin stall_pct = 25; ready_pct = 90;  redir_pct = 20; lat_lo = 1; lat_hi = 2; end
            endcase
            stall          = ($urandom_range(99, 0) < stall_pct);
            imem_req_ready = ($urandom_range(99, 0) < ready_pct);
            redirect_valid = rst && ($urandom_range(99, 0) < redir_pct);
            redirect_pc    = ($urandom_range(2, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0)) : $urandom;
            imem_resp_valid = rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
            imem_resp_data  = imem_resp_valid ? mem_word(mem_q[0].addr) : $urandom;
            exp_rv   = rst && !redirect_valid && ((m_out.size() + m_buf.size()) < 2);
            exp_iv   = (m_buf.size() > 0);
            exp_inst = exp_iv ? m_buf[0].inst : 32'h0;
            exp_pc   = exp_iv ? m_buf[0].pc   : 32'h0;
            #1;
            check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
            check("req_addr", imem_req_addr, m_pc);
            check("inst_valid", {31'b0, inst_valid_out}, {31'b0, exp_iv});
            check("inst_out", inst_out, exp_inst);
            check("pc_out", pc_out, exp_pc);
`ifdef FETCH_STATS_EN
            check("fetch_count", fetch_count, m_fetch);
            check("flush_count", {16'b0, flush_count}, {16'b0, m_flush});
`endif
            @(posedge clk);
            if (rst) model_step();
            cyc++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
